disaggregator: RTL

//  Width converter that is the counterpart of the aggregator. It pops one packed word of

---
 rtl/disaggregator_pkg.sv | 10 +
 rtl/disaggregator_lane_select.sv | 23 ++
 rtl/disaggregator.sv | 91 +++++++++
 3 files changed

// File: rtl/disaggregator_pkg.sv
// Shared helpers for the disaggregator width converter.
// Keeps the lane-index sizing rule in one place for the top and the lane mux.
package disaggregator_pkg;

    // A single-lane word still needs a 1-bit index so ports never collapse to zero width.
    function automatic int calc_idx_width(input int fetch_width);
        return (fetch_width > 1) ? $clog2(fetch_width) : 1;
    endfunction

endpackage

// File: rtl/disaggregator_lane_select.sv
// Parameterised FETCH_WIDTH:1 multiplexer picking one DATA_WIDTH lane out of a packed word.
module disaggregator_lane_select
    import disaggregator_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FETCH_WIDTH = 4,
    parameter int IDX_WIDTH   = calc_idx_width(FETCH_WIDTH)
) (
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] lanes,
    input  logic [IDX_WIDTH-1:0]              sel,
    output logic [DATA_WIDTH-1:0]             data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (sel == IDX_WIDTH'(i)) begin
                data = lanes[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/disaggregator.sv
// Wide-to-narrow converter: pops one packed word from a show-ahead FIFO and
// emits its lanes one per cycle, lane 0 first, with no bubble between words.
module disaggregator
    import disaggregator_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FETCH_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    output logic                              receiver_last
);

    localparam int IDX_WIDTH = calc_idx_width(FETCH_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FETCH_WIDTH - 1);

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] word_q, word_d;
    logic                              valid_q, valid_d;
    logic [IDX_WIDTH-1:0]              idx_q, idx_d;

    logic                  on_last;
    logic                  enq;
    logic                  deq;
    logic [DATA_WIDTH-1:0] lane_data;

    disaggregator_lane_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .FETCH_WIDTH(FETCH_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_lane_select (
        .lanes(word_q),
        .sel  (idx_q),
        .data (lane_data)
    );

    // A new word may only be popped when nothing is held or the held word's last lane leaves now.
    always_comb begin
        on_last = valid_q && (idx_q == LAST_IDX);
        enq     = valid_q && receiver_full_n && !clr;
        deq     = sender_empty_n && !clr && (!valid_q || (enq && on_last));
    end

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        if (clr) begin
            valid_d = 1'b0;
            idx_d   = '0;
        end else if (deq) begin
            word_d  = sender_data;
            valid_d = 1'b1;
            idx_d   = '0;
        end else if (enq) begin
            if (on_last) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // Handshakes are masked during reset so neither FIFO moves while state is being cleared.
    always_comb begin
        sender_deq    = deq && !rst;
        receiver_enq  = enq && !rst;
        receiver_last = on_last && !rst;
        receiver_data = rst ? '0 : lane_data;
    end

endmodule
